// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl
//   Initiator-side controller for a single-port SRAM array. Takes one
//   read or write request at a time on a valid/ready request channel,
//   drives the array address/data/write-enable pins, waits RD_LAT cycles
//   for read data and returns it on a valid/ready response channel.
//
// Parameters
//   ADDR_W  address width (array depth 2**ADDR_W)
//   DATA_W  data word width
//   RD_LAT  array read latency in cycles, 1..4
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_we/req_addr/req_wdata     request kind, address, write data
//   rsp_valid/rsp_ready/rsp_rdata read response channel
//   mem_addr/mem_din/mem_we       to array addr/din/we
//   mem_dout                      from array dout
//   busy                          high whenever not IDLE (and during reset)
//
// Build option
//   SRAM_CTRL_CLEAR_EN  when defined, an INIT sweep writes zero to every
//                       address after reset before requests are accepted.
module sram_access_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

`ifdef SRAM_CTRL_CLEAR_EN
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_WR, S_RD, S_RSP} state_t;
  localparam state_t RESET_STATE = S_INIT;
`else
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RSP} state_t;
  localparam state_t RESET_STATE = S_IDLE;
`endif

  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        lat_q, lat_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_STATE;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    lat_d   = lat_q;
    unique case (state_q)
`ifdef SRAM_CTRL_CLEAR_EN
      // The address register doubles as the sweep counter; din stays at
      // its reset value of zero. Hold the last address on exit.
      S_INIT: begin
        if (addr_q == '1) state_d = S_IDLE;
        else              addr_d  = addr_q + ADDR_W'(1);
      end
`endif
      S_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          if (req_we) begin
            din_d   = req_wdata;
            state_d = S_WR;
          end else begin
            lat_d   = LAT_LOAD;
            state_d = S_RD;
          end
        end
      end
      S_WR: state_d = S_IDLE;
      S_RD: begin
        if (lat_q == '0) begin
          rdata_d = mem_dout;
          state_d = S_RSP;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      S_RSP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake-facing outputs are masked by rst so nothing is offered or
  // written while reset is held, whatever state the register holds.
  assign req_ready = (state_q == S_IDLE) && !rst;
  assign rsp_valid = (state_q == S_RSP) && !rst;
  assign rsp_rdata = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_din   = din_q;
`ifdef SRAM_CTRL_CLEAR_EN
  assign mem_we    = ((state_q == S_WR) || (state_q == S_INIT)) && !rst;
`else
  assign mem_we    = (state_q == S_WR) && !rst;
`endif
  assign busy      = rst || (state_q != S_IDLE);

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl: one instance with RD_LAT=1 and one
// with RD_LAT=3, each attached to a behavioural array model.
module tb_sram_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, mem_we, busy;
  logic [7:0]  req_addr, mem_addr;
  logic [31:0] req_wdata, rsp_rdata, mem_din, mem_dout;

  logic        req_valid3, req_ready3, req_we3, rsp_valid3, rsp_ready3, mem_we3, busy3;
  logic [7:0]  req_addr3, mem_addr3;
  logic [31:0] req_wdata3, rsp_rdata3, mem_din3, mem_dout3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_access_ctrl #(.ADDR_W(8), .DATA_W(32), .RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout), .busy(busy)
  );

  sram_access_ctrl #(.ADDR_W(8), .DATA_W(32), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_we(req_we3),
    .req_addr(req_addr3), .req_wdata(req_wdata3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3),
    .mem_addr(mem_addr3), .mem_din(mem_din3), .mem_we(mem_we3),
    .mem_dout(mem_dout3), .busy(busy3)
  );

  // Array models: latency 1 = data for the current address within the
  // cycle; latency 3 = two address pipeline stages before the lookup.
  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];
  logic [7:0]  addr3_p1, addr3_p2;

  always @(posedge clk) if (mem_we) mem1[mem_addr] <= mem_din;
  assign mem_dout = mem1[mem_addr];

  always @(posedge clk) begin
    if (mem_we3) mem3[mem_addr3] <= mem_din3;
    addr3_p1 <= mem_addr3;
    addr3_p2 <= addr3_p1;
  end
  assign mem_dout3 = mem3[addr3_p2];

  `define CHK(tag, obs, exp) \
    begin \
      n_tests++; \
      assert ((obs) === (exp)) else begin \
        n_fail++; \
        $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
      end \
    end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    step();
    req_valid = 1'b0;
    step();
  endtask

  task automatic do_write3(input logic [7:0] a, input logic [31:0] d);
    req_valid3 = 1'b1; req_we3 = 1'b1; req_addr3 = a; req_wdata3 = d;
    step();
    req_valid3 = 1'b0;
    step();
  endtask

  // Returns the data and the number of cycles from accept to rsp_valid.
  task automatic do_read(input logic [7:0] a, output logic [31:0] d, output int lat);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    step();
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 10) begin
      step();
      lat++;
    end
    d = rsp_rdata;
    step();
  endtask

  // Releases reset and waits for IDLE, counting any response seen meanwhile
  // and for three cycles after.
  task automatic release_and_watch(output int late, output int waited);
    rst = 1'b0;
    #1;
    late = 0;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 300) begin
      if (rsp_valid) late++;
      step();
      waited++;
    end
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid) late++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int          lat, late, waited;

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    req_valid3 = 1'b0; req_we3 = 1'b0; req_addr3 = '0; req_wdata3 = '0; rsp_ready3 = 1'b1;

    step();
    step();
    `CHK("rst_req_ready", req_ready, 1'b0)
    `CHK("rst_rsp_valid", rsp_valid, 1'b0)
    `CHK("rst_rsp_rdata", rsp_rdata, 32'h0)
    `CHK("rst_mem_we", mem_we, 1'b0)
    `CHK("rst_mem_addr", mem_addr, 8'h00)
    `CHK("rst_mem_din", mem_din, 32'h0)
    `CHK("rst_busy", busy, 1'b1)
    `CHK("rst_busy3", busy3, 1'b1)

    rst = 1'b0;
    #1;
`ifdef SRAM_CTRL_CLEAR_EN
    begin
      int low = 0, pulses = 0, order_err = 0;
      while (req_ready !== 1'b1 && low < 300) begin
        if (mem_we) begin
          if (mem_addr !== 8'(pulses) || mem_din !== 32'h0) order_err++;
          pulses++;
        end
        low++;
        step();
      end
      `CHK("clr_ready_low_cycles", low, 256)
      `CHK("clr_we_pulses", pulses, 256)
      `CHK("clr_order", order_err, 0)
      do_write(8'hFF, 32'h1111_2222);
      // a fresh reset reruns the sweep, so 0xFF must read back zero
      rst = 1'b1;
      step();
      release_and_watch(late, waited);
      `CHK("clr_rerun_done", waited, 256)
      do_read(8'hFF, rd, lat);
      `CHK("clr_read_ff", rd, 32'h0)
    end
`else
    `CHK("idle_req_ready", req_ready, 1'b1)
    `CHK("idle_busy", busy, 1'b0)
    `CHK("idle_req_ready3", req_ready3, 1'b1)
`endif

    // write 0xA5A5_0001 to 0x10, inline so the write pulse is visible
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_wdata = 32'hA5A5_0001;
    step();
    req_valid = 1'b0;
    `CHK("wr_mem_we", mem_we, 1'b1)
    `CHK("wr_mem_addr", mem_addr, 8'h10)
    `CHK("wr_mem_din", mem_din, 32'hA5A5_0001)
    `CHK("wr_req_ready", req_ready, 1'b0)
    step();
    `CHK("wr_we_one_cycle", mem_we, 1'b0)
    `CHK("wr_ready_again", req_ready, 1'b1)
    `CHK("wr_addr_held", mem_addr, 8'h10)

    // read 0x10 back, RD_LAT=1
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
    step();
    req_valid = 1'b0;
    `CHK("rd_rsp_valid_n1", rsp_valid, 1'b0)
    `CHK("rd_mem_addr", mem_addr, 8'h10)
    `CHK("rd_mem_we", mem_we, 1'b0)
    step();
    `CHK("rd_rsp_valid_n2", rsp_valid, 1'b1)
    `CHK("rd_rsp_rdata", rsp_rdata, 32'hA5A5_0001)
    step();
    `CHK("rd_idle_n3", req_ready, 1'b1)
    `CHK("rd_rsp_drop", rsp_valid, 1'b0)

    // response back-pressure for 5 cycles
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
    step();
    req_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      `CHK("bp_rsp_valid", rsp_valid, 1'b1)
      `CHK("bp_rsp_rdata", rsp_rdata, 32'hA5A5_0001)
      `CHK("bp_req_ready", req_ready, 1'b0)
      if (i < 4) step();
    end
    rsp_ready = 1'b1;
    step();
    `CHK("bp_idle_after", req_ready, 1'b1)
    `CHK("bp_rsp_drop", rsp_valid, 1'b0)

    // boundary addresses
    do_write(8'hFF, 32'hDEAD_BEEF);
    do_write(8'h00, 32'h1234_5678);
    do_read(8'hFF, rd, lat);
    `CHK("bnd_read_ff", rd, 32'hDEAD_BEEF)
    `CHK("bnd_lat_ff", lat, 2)
    do_read(8'h00, rd, lat);
    `CHK("bnd_read_00", rd, 32'h1234_5678)
    do_read(8'h10, rd, lat);
    `CHK("bnd_read_10", rd, 32'hA5A5_0001)

    // RD_LAT=3 instance; 0x43 written last so an early capture would see it
    do_write3(8'h42, 32'h4242_0042);
    do_write3(8'h43, 32'h4343_0043);
    req_valid3 = 1'b1; req_we3 = 1'b0; req_addr3 = 8'h42;
    step();
    for (int i = 0; i < 3; i++) begin
      `CHK("l3_mem_addr", mem_addr3, 8'h42)
      `CHK("l3_rsp_valid_low", rsp_valid3, 1'b0)
      `CHK("l3_req_ready_low", req_ready3, 1'b0)
      `CHK("l3_mem_we", mem_we3, 1'b0)
      step();
    end
    `CHK("l3_rsp_valid_n4", rsp_valid3, 1'b1)
    `CHK("l3_rsp_rdata", rsp_rdata3, 32'h4242_0042)
    step();
    req_valid3 = 1'b0;
    `CHK("l3_idle_n5", req_ready3, 1'b1)

    // reset during RD
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
    step();
    req_valid = 1'b0;
    rst = 1'b1;
    step();
    `CHK("rstrd_rsp_valid", rsp_valid, 1'b0)
    `CHK("rstrd_mem_we", mem_we, 1'b0)
    `CHK("rstrd_mem_addr", mem_addr, 8'h00)
    `CHK("rstrd_req_ready", req_ready, 1'b0)
    release_and_watch(late, waited);
    `CHK("rstrd_no_late_rsp", late, 0)
    `CHK("rstrd_reached_idle", req_ready, 1'b1)

    // reset during RSP
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
    step();
    req_valid = 1'b0;
    step();
    `CHK("rstrsp_valid_before", rsp_valid, 1'b1)
    rst = 1'b1;
    step();
    `CHK("rstrsp_rsp_valid", rsp_valid, 1'b0)
    `CHK("rstrsp_rsp_rdata", rsp_rdata, 32'h0)
    `CHK("rstrsp_mem_we", mem_we, 1'b0)
    rsp_ready = 1'b1;
    release_and_watch(late, waited);
    `CHK("rstrsp_no_late_rsp", late, 0)

    // controller still functional after reset
    do_read(8'hFF, rd, lat);
`ifdef SRAM_CTRL_CLEAR_EN
    `CHK("post_rst_read", rd, 32'h0)
`else
    `CHK("post_rst_read", rd, 32'hDEAD_BEEF)
`endif
    `CHK("post_rst_lat", lat, 2)

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
